// File: rtl/addr8s_sub_serial.sv
// ============================================================================
// addr8s_sub_serial
//
// Purpose:
//   Bit-serial signed inverse of the 8-bit signed adder. Given a signed sum
//   S (WIDTH+1 bits) and one signed operand A (WIDTH bits), it recovers the
//   other operand B = S - A. It works one bit per clock, LSB first, over a
//   WIDTH+2 bit two's complement datapath, so the subtraction itself never
//   wraps. The result is flagged when it does not fit in WIDTH signed bits.
//
// Optional build macro:
//   SUB_DMR_EN - adds a second, independent serial subtractor that runs in
//                lockstep on the same operands. The two full-width results
//                are compared and any disagreement raises fault_err. With
//                the macro undefined there is one datapath and fault_err is
//                tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   S/A present
//   in_ready   out  block can accept (IDLE only)
//   s_in       in   [WIDTH:0]   signed sum operand S
//   a_in       in   [WIDTH-1:0] signed operand A
//   out_valid  out  result present (DONE)
//   out_ready  in   consumer takes result
//   b_out      out  [WIDTH-1:0] low WIDTH bits of S - A
//   range_err  out  S - A outside the WIDTH-bit signed range
//   busy       out  high in SHIFT or DONE
//   fault_err  out  lockstep copies disagree (SUB_DMR_EN only, else 0)
// ============================================================================
module addr8s_sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   s_in,
    input  logic [WIDTH-1:0] a_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_out,
    output logic             range_err,
    output logic             busy,
    output logic             fault_err
);

    // Datapath width: one guard bit above S so that S - A is always exact.
    localparam int DW = WIDTH + 2;
    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;

    logic [DW-1:0]   r_sReg;
    logic [DW-1:0]   r_aReg;
    logic [DW-1:0]   r_diff0;
    logic            r_borrow0;
    logic [CW-1:0]   r_count;
    logic [WIDTH-1:0] r_bOut;
    logic            r_rangeErr;

    logic            w_inReady;
    logic            w_outValid;
    logic            w_busy;
    logic            w_accept;
    logic            w_lastBit;

    logic            w_sBit;
    logic            w_aBit;
    logic            w_d0;
    logic            w_borrowNext0;
    logic [DW-1:0]   w_diffFinal0;
    logic [2:0]      w_topBits0;

    // The state register only; all decisions about where to go next live in
    // the combinational block below.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake decode. The accept and last-bit strobes are
    // produced here so the datapath block does not need to re-derive them.
    always_comb begin
        w_stateNext = r_state;
        w_inReady   = 1'b0;
        w_outValid  = 1'b0;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        w_lastBit   = 1'b0;
        case (r_state)
            IDLE: begin
                w_inReady = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_stateNext = SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (r_count == LAST_COUNT) begin
                    w_lastBit   = 1'b1;
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_busy     = 1'b1;
                w_outValid = 1'b1;
                if (out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // One full-subtractor slice: difference bit and borrow-out for the
    // current LSBs of the operand shift registers.
    always_comb begin
        w_sBit        = r_sReg[0];
        w_aBit        = r_aReg[0];
        w_d0          = w_sBit ^ w_aBit ^ r_borrow0;
        w_borrowNext0 = (~w_sBit & w_aBit) | (~(w_sBit ^ w_aBit) & r_borrow0);
        // Value the result register will hold after the final shift; used
        // to load the output registers on the same edge.
        w_diffFinal0  = {w_d0, r_diff0[DW-1:1]};
        w_topBits0    = w_diffFinal0[WIDTH+1:WIDTH-1];
    end

    // Serial datapath. Operands are sign-extended on accept, then shifted
    // right one bit per edge while difference bits enter from the MSB side,
    // so after DW edges the result register holds the full difference.
    // b_out/range_err are separate registers so they keep the previous
    // result through IDLE and SHIFT and only change when a new one is ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sReg     <= '0;
            r_aReg     <= '0;
            r_diff0    <= '0;
            r_borrow0  <= 1'b0;
            r_count    <= '0;
            r_bOut     <= '0;
            r_rangeErr <= 1'b0;
        end else if (w_accept) begin
            r_sReg    <= {s_in[WIDTH], s_in};
            r_aReg    <= {{2{a_in[WIDTH-1]}}, a_in};
            r_diff0   <= '0;
            r_borrow0 <= 1'b0;
            r_count   <= '0;
        end else if (r_state == SHIFT) begin
            r_sReg    <= {1'b0, r_sReg[DW-1:1]};
            r_aReg    <= {1'b0, r_aReg[DW-1:1]};
            r_diff0   <= w_diffFinal0;
            r_borrow0 <= w_borrowNext0;
            r_count   <= r_count + 1'b1;
            if (w_lastBit) begin
                r_bOut <= w_diffFinal0[WIDTH-1:0];
                // The value fits in WIDTH signed bits only when the two
                // guard bits are copies of the WIDTH-bit sign bit.
                r_rangeErr <= ~((&w_topBits0) | ~(|w_topBits0));
            end
        end
    end

`ifdef SUB_DMR_EN
    logic [DW-1:0] r_diff1;
    logic          r_borrow1;
    logic          r_faultErr;
    logic          w_d1;
    logic          w_borrowNext1;
    logic [DW-1:0] w_diffFinal1;

    // Second subtractor slice fed from the same operand bits but with its
    // own borrow, so a corrupted borrow or result bit in either copy shows up.
    always_comb begin
        w_d1          = w_sBit ^ w_aBit ^ r_borrow1;
        w_borrowNext1 = (~w_sBit & w_aBit) | (~(w_sBit ^ w_aBit) & r_borrow1);
        w_diffFinal1  = {w_d1, r_diff1[DW-1:1]};
    end

    // Lockstep copy state plus the fault flag. The flag is decided on the
    // final shift edge and is dropped on the same edge that drops out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_diff1    <= '0;
            r_borrow1  <= 1'b0;
            r_faultErr <= 1'b0;
        end else if (w_accept) begin
            r_diff1   <= '0;
            r_borrow1 <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_diff1   <= w_diffFinal1;
            r_borrow1 <= w_borrowNext1;
            if (w_lastBit) begin
                r_faultErr <= (w_diffFinal0 != w_diffFinal1);
            end
        end else if ((r_state == DONE) && out_ready) begin
            r_faultErr <= 1'b0;
        end
    end

    assign fault_err = r_faultErr;
`else
    assign fault_err = 1'b0;
`endif

    assign in_ready  = w_inReady;
    assign out_valid = w_outValid;
    assign busy      = w_busy;
    assign b_out     = r_bOut;
    assign range_err = r_rangeErr;

endmodule

// File: tb/tb_addr8s_sub_serial.sv
// ============================================================================
// tb_addr8s_sub_serial
//
// Self-checking bench for addr8s_sub_serial. Expected results come from a
// plain integer model of S - A; a compare process checks every cycle in which
// out_valid is high, and directed transactions also pin literal results.
// ============================================================================
module tb_addr8s_sub_serial;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] s_in;
    logic [7:0] a_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] b_out;
    logic       range_err;
    logic       busy;
    logic       fault_err;

    int         errors;
    int         checks;

    // Model expectations for the transaction currently in flight.
    logic [7:0] expB;
    logic       expErr;
    logic       expFault;
    logic       pending;

    // What the DUT presented when the result first appeared.
    logic [7:0] lastB;
    logic       lastErr;

    addr8s_sub_serial #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_in      (s_in),
        .a_in      (a_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_out     (b_out),
        .range_err (range_err),
        .busy      (busy),
        .fault_err (fault_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single point where every comparison is counted and reported.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Behavioural model: exact signed integer subtraction.
    task automatic modelSub(input logic [8:0] s, input logic [7:0] a,
                            output logic [7:0] b, output logic err);
        int          diff;
        logic [31:0] bits;
        diff = int'($signed(s)) - int'($signed(a));
        bits = diff;
        b    = bits[7:0];
        err  = (diff < -128) || (diff > 127);
    endtask

    // Compare process: whenever a result is presented, it must be the one
    // the model predicts for the accepted transaction.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("busy_vs_ready", busy, !in_ready);
            if (out_valid) begin
                checkOutput("valid_pending", pending, 1);
                checkOutput("b_out", b_out, expB);
                checkOutput("range_err", range_err, expErr);
                checkOutput("fault_err", fault_err, expFault);
                checkOutput("in_ready_done", in_ready, 0);
            end else begin
                checkOutput("fault_idle", fault_err, 0);
            end
        end
    end

    // Runs one transaction from IDLE: accept, latency measurement, optional
    // backpressure with an ignored in_valid pulse, then the output handshake.
    // Called and returns just after a rising edge with the DUT in IDLE.
    task automatic applyStimulus(input logic [8:0] s, input logic [7:0] a,
                                 input int stall);
        int lat;
        checkOutput("in_ready_idle", in_ready, 1);
        modelSub(s, a, expB, expErr);
        s_in      = s;
        a_in      = a;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        pending = 1'b1;
        #1;
        in_valid = 1'b0;
        s_in     = 9'($urandom);
        a_in     = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, 10);
        lastB   = b_out;
        lastErr = range_err;
        for (int i = 0; i < stall; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                s_in     = 9'($urandom);
                a_in     = 8'($urandom);
            end
            @(posedge clk);
            #1;
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_ready", in_ready, 0);
            checkOutput("stall_b", b_out, lastB);
            checkOutput("stall_err", range_err, lastErr);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        pending = 1'b0;
        checkOutput("valid_drop", out_valid, 0);
        checkOutput("ready_back", in_ready, 1);
        checkOutput("b_hold", b_out, expB);
        out_ready = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        pending   = 1'b0;
        expB      = '0;
        expErr    = 1'b0;
        expFault  = 1'b0;
        lastB     = '0;
        lastErr   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s_in      = '0;
        a_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_b_out", b_out, 0);
        checkOutput("rst_range_err", range_err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_fault", fault_err, 0);

        // Directed cases with hand-computed results.
        applyStimulus(9'h00F, 8'h05, 0);
        checkOutput("lit_0f_05_b", lastB, 8'h0A);
        checkOutput("lit_0f_05_err", lastErr, 0);
        applyStimulus(9'h1FF, 8'h80, 0);
        checkOutput("lit_m1_m128_b", lastB, 8'h7F);
        checkOutput("lit_m1_m128_err", lastErr, 0);
        applyStimulus(9'h100, 8'h7F, 0);
        checkOutput("lit_m256_127_b", lastB, 8'h81);
        checkOutput("lit_m256_127_err", lastErr, 1);
        applyStimulus(9'h0FF, 8'h80, 5);
        checkOutput("lit_255_m128_b", lastB, 8'h7F);
        checkOutput("lit_255_m128_err", lastErr, 1);

        // Reset on the 4th shift edge discards the transaction.
        s_in     = 9'h00F;
        a_in     = 8'h05;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_b_out", b_out, 0);
        checkOutput("midrst_range_err", range_err, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_fault", fault_err, 0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            checkOutput("no_partial", out_valid, 0);
        end
        applyStimulus(9'h003, 8'h01, 0);
        checkOutput("lit_3_1_b", lastB, 8'h02);
        checkOutput("lit_3_1_err", lastErr, 0);

        // Randomized transactions against the model.
        for (int n = 0; n < 256; n++) begin
            applyStimulus(9'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

`ifdef SUB_DMR_EN
        // Corrupt copy 1's borrow so the two results must disagree.
        force dut.r_borrow1 = 1'b1;
        expFault = 1'b1;
        applyStimulus(9'h00F, 8'h05, 2);
        release dut.r_borrow1;
        expFault = 1'b0;
        checkOutput("fault_clears", fault_err, 0);
        applyStimulus(9'h003, 8'h01, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
